// File: rtl/msx_slot_ctrl_pkg.sv
// Shared MSX slot definitions: bus constants, slot type and the 2-bit
// field extractor used for both primary and secondary slot registers.
package msx_slot_ctrl_pkg;

  typedef logic [1:0] slot_t;

  localparam logic [7:0]  PPI_PSLOT_PORT   = 8'hA8;
  localparam logic [15:0] SUBSLOT_REG_ADDR = 16'hFFFF;

  // A slot-select byte packs one 2-bit slot number per 16 KiB page.
  function automatic slot_t page_field(input logic [7:0] sel, input logic [1:0] page);
    return sel[{page, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/msx_slot_ctrl_if.sv
// Z80-side bus bundle between the CPU core (master) and the slot
// controller (slave), including the decoded slot outputs.
interface msx_slot_ctrl_if;
  import msx_slot_ctrl_pkg::*;

  logic [15:0] addr;
  logic [7:0]  d_from_cpu;
  logic [7:0]  d_to_cpu;
  logic        dataBusRQ;
  logic        wr_n;
  logic        rd_n;
  logic        iorq_n;
  logic        mreq_n;
  logic        m1_n;
  logic        rfrsh_n;
  logic        wait_n;
  logic [3:0]  SLTSL_n;
  slot_t       slot;
  slot_t       sub_slot;

  modport master (
    output addr, d_from_cpu, wr_n, rd_n, iorq_n, mreq_n, m1_n, rfrsh_n,
    input  d_to_cpu, dataBusRQ, wait_n, SLTSL_n, slot, sub_slot
  );

  modport slave (
    input  addr, d_from_cpu, wr_n, rd_n, iorq_n, mreq_n, m1_n, rfrsh_n,
    output d_to_cpu, dataBusRQ, wait_n, SLTSL_n, slot, sub_slot
  );

endinterface

// File: rtl/msx_slot_ctrl_bus_cycle_strobe.sv
// Once-per-bus-cycle write strobe: fires on the first clock that sees a
// write, then stays quiet until both IORQ and MREQ have been released.
module msx_slot_ctrl_bus_cycle_strobe (
  input  logic clk_i,
  input  logic rst_i,
  input  logic iorq_n_i,
  input  logic mreq_n_i,
  input  logic wr_n_i,
  output logic strobe_o
);

  logic ack_q;
  logic ack_d;

  always_comb begin
    strobe_o = (~iorq_n_i | ~mreq_n_i) & ~wr_n_i & ~ack_q;
    ack_d    = ack_q;
    if (iorq_n_i & mreq_n_i) begin
      ack_d = 1'b0;
    end else if (strobe_o) begin
      ack_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_q <= 1'b0;
    end else begin
      ack_q <= ack_d;
    end
  end

endmodule

// File: rtl/msx_slot_ctrl.sv
// MSX primary/secondary slot controller: port A8 and FFFF slot registers,
// per-page slot decode with SLTSL_n generation, and the M1 wait state.
module msx_slot_ctrl
  import msx_slot_ctrl_pkg::*;
#(
  parameter logic [3:0] EXPANDED   = 4'b1000,
  parameter int          M1_WAIT    = 1,
  parameter logic [7:0]  PSLOT_INIT = 8'h00
) (
  input  logic           clk21m,
  input  logic           reset,
  input  logic           ce_3m58,
  msx_slot_ctrl_if.slave bus
);

  localparam int CNT_W = (M1_WAIT > 1) ? $clog2(M1_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(M1_WAIT);
  localparam logic WAIT_EN = (M1_WAIT > 0);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [7:0]       pslot_q, pslot_d;
  logic [7:0]       sub_q [4];
  logic [7:0]       sub_d [4];
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wait_n_q, wait_n_d;

  logic [1:0] page;
  slot_t      cur_slot;
  slot_t      page3_slot;
  logic       io_en;
  logic       ss_en;
  logic       wr_strobe;
  logic [3:0] sltsl_n;
  logic [7:0] rd_data;

  msx_slot_ctrl_bus_cycle_strobe u_strobe (
    .clk_i    (clk21m),
    .rst_i    (reset),
    .iorq_n_i (bus.iorq_n),
    .mreq_n_i (bus.mreq_n),
    .wr_n_i   (bus.wr_n),
    .strobe_o (wr_strobe)
  );

  // FFFF always lives in page 3, so its owner is the page-3 primary slot.
  always_comb begin
    page       = bus.addr[15:14];
    cur_slot   = page_field(pslot_q, page);
    page3_slot = page_field(pslot_q, 2'd3);
    io_en      = (bus.addr[7:0] == PPI_PSLOT_PORT) & ~bus.iorq_n & bus.m1_n;
    ss_en      = (bus.addr == SUBSLOT_REG_ADDR) & ~bus.mreq_n & bus.rfrsh_n
                 & EXPANDED[page3_slot];
  end

  always_comb begin
    sltsl_n = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      if ((cur_slot == slot_t'(i)) & ~bus.mreq_n & bus.rfrsh_n & ~ss_en) begin
        sltsl_n[i] = 1'b0;
      end
    end
  end

  always_comb begin
    rd_data = 8'hFF;
    if (~bus.rd_n) begin
      if (io_en) begin
        rd_data = pslot_q;
      end else if (ss_en) begin
        rd_data = ~sub_q[page3_slot];
      end
    end
  end

  assign bus.slot      = cur_slot;
  assign bus.sub_slot  = EXPANDED[cur_slot] ? page_field(sub_q[cur_slot], page) : 2'b00;
  assign bus.SLTSL_n   = sltsl_n;
  assign bus.d_to_cpu  = rd_data;
  assign bus.dataBusRQ = ~bus.rd_n & (io_en | ss_en);
  assign bus.wait_n    = wait_n_q;

  always_comb begin
    pslot_d = pslot_q;
    for (int i = 0; i < 4; i++) begin
      sub_d[i] = sub_q[i];
    end
    if (wr_strobe) begin
      if (io_en) begin
        pslot_d = bus.d_from_cpu;
      end
      if (ss_en) begin
        sub_d[page3_slot] = bus.d_from_cpu;
      end
    end
  end

  always_ff @(posedge clk21m) begin
    if (reset) begin
      pslot_q <= PSLOT_INIT;
      for (int i = 0; i < 4; i++) begin
        sub_q[i] <= 8'h00;
      end
    end else begin
      pslot_q <= pslot_d;
      for (int i = 0; i < 4; i++) begin
        sub_q[i] <= sub_d[i];
      end
    end
  end

  // HOLD keeps a long M1 cycle from triggering a second wait.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wait_n_d = wait_n_q;
    case (state_q)
      ST_IDLE: begin
        if (WAIT_EN & ~bus.m1_n & (~bus.mreq_n | ~bus.iorq_n)) begin
          state_d  = ST_WAIT;
          wait_n_d = 1'b0;
          cnt_d    = CNT_INIT;
        end
      end
      ST_WAIT: begin
        if (ce_3m58) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            wait_n_d = 1'b1;
            state_d  = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (bus.m1_n) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        wait_n_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk21m) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      wait_n_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wait_n_q <= wait_n_d;
    end
  end

endmodule

// File: tb/tb_msx_slot_ctrl.sv
// Scoreboard bench for msx_slot_ctrl: bus cycles push predicted decode
// results from a slot-map model; a monitor compares at each new cycle.
module tb_msx_slot_ctrl;

  localparam logic [3:0] EXPANDED   = 4'b1000;
  localparam int         M1_WAIT    = 1;
  localparam logic [7:0] PSLOT_INIT = 8'h00;

  typedef struct {
    string      tag;
    logic [7:0] d;
    logic       rq;
    logic [3:0] sltsl;
    logic [1:0] slot;
    logic [1:0] sub;
  } exp_t;

  logic clk21m  = 1'b0;
  logic reset   = 1'b1;
  logic ce_3m58 = 1'b0;

  int checks = 0;
  int errors = 0;

  exp_t       expQ[$];
  logic [7:0] pslotM;
  logic [7:0] subM [4];

  msx_slot_ctrl_if bus ();

  msx_slot_ctrl #(
    .EXPANDED   (EXPANDED),
    .M1_WAIT    (M1_WAIT),
    .PSLOT_INIT (PSLOT_INIT)
  ) dut (
    .clk21m  (clk21m),
    .reset   (reset),
    .ce_3m58 (ce_3m58),
    .bus     (bus)
  );

  always #5 clk21m = ~clk21m;

  // 3.58 MHz enable: one clock wide, every sixth clock.
  initial begin
    forever begin
      repeat (5) @(posedge clk21m);
      #2 ce_3m58 = 1'b1;
      @(posedge clk21m);
      #2 ce_3m58 = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  task automatic modelReset();
    pslotM = PSLOT_INIT;
    for (int i = 0; i < 4; i++) subM[i] = 8'h00;
  endtask

  function automatic exp_t predict(input string tag, input bit isIo, input bit rd,
                                   input bit m1, input bit refresh, input logic [15:0] a);
    exp_t e;
    int   page, sl, s3;
    bit   ioHit, ssHit;
    page  = int'(a[15:14]);
    sl    = int'((pslotM >> (2 * page)) & 8'h03);
    s3    = int'(pslotM[7:6]);
    ioHit = isIo && (a[7:0] == 8'hA8) && !m1;
    ssHit = !isIo && (a == 16'hFFFF) && !refresh && EXPANDED[s3];
    e.tag  = tag;
    e.slot = 2'(sl);
    e.sub  = EXPANDED[sl] ? 2'((subM[sl] >> (2 * page)) & 8'h03) : 2'b00;
    e.d    = 8'hFF;
    if (rd) begin
      if (ioHit) e.d = pslotM;
      else if (ssHit) e.d = ~subM[s3];
    end
    e.rq    = rd && (ioHit || ssHit);
    e.sltsl = 4'hF;
    if (!isIo && !refresh && !ssHit) e.sltsl[sl] = 1'b0;
    return e;
  endfunction

  task automatic modelWrite(input bit isIo, input logic [15:0] a, input logic [7:0] d);
    int s3;
    s3 = int'(pslotM[7:6]);
    if (isIo && a[7:0] == 8'hA8) pslotM = d;
    else if (!isIo && a == 16'hFFFF && EXPANDED[s3]) subM[s3] = d;
  endtask

  task automatic idleBus();
    bus.addr       = 16'h0000;
    bus.d_from_cpu = 8'h00;
    bus.wr_n       = 1'b1;
    bus.rd_n       = 1'b1;
    bus.iorq_n     = 1'b1;
    bus.mreq_n     = 1'b1;
    bus.m1_n       = 1'b1;
    bus.rfrsh_n    = 1'b1;
  endtask

  task automatic driveBus(input bit isIo, input bit rd, input bit wr, input bit m1,
                          input bit refresh, input logic [15:0] a, input logic [7:0] d);
    bus.addr       = a;
    bus.d_from_cpu = d;
    bus.iorq_n     = !isIo;
    bus.mreq_n     = isIo;
    bus.rd_n       = !rd;
    bus.wr_n       = !wr;
    bus.m1_n       = !m1;
    bus.rfrsh_n    = !refresh;
  endtask

  // Write data is scrambled after the commit edge; only the first value may land.
  task automatic applyStimulus(input string tag, input bit isIo, input bit rd, input bit wr,
                               input bit refresh, input logic [15:0] a, input logic [7:0] d,
                               input int hold);
    expQ.push_back(predict(tag, isIo, rd, 1'b0, refresh, a));
    if (wr) modelWrite(isIo, a, d);
    @(posedge clk21m);
    #3 driveBus(isIo, rd, wr, 1'b0, refresh, a, d);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk21m);
      #3;
      if (wr) bus.d_from_cpu = 8'($urandom);
    end
    idleBus();
    @(posedge clk21m);
  endtask

  task automatic alignToCe();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk21m);
      #3;
      if (ce_3m58) return;
    end
    checkOutput("ce alignment", 32'd0, 32'd1);
  endtask

  task automatic m1WaitTest(input string tag, input bit intAck);
    logic [15:0] a;
    int          remaining, lowCount;
    logic        expWait, ceBefore;
    a = 16'($urandom_range(0, 16'h3FFF));
    alignToCe();
    expQ.push_back(predict(tag, intAck, !intAck, 1'b1, 1'b0, a));
    driveBus(intAck, !intAck, 1'b0, 1'b1, 1'b0, a, 8'h00);
    remaining = M1_WAIT;
    lowCount  = 0;
    expWait   = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      ceBefore = ce_3m58;
      if (cyc == 0) begin
        expWait = (M1_WAIT > 0) ? 1'b0 : 1'b1;
      end else if (!expWait && ceBefore) begin
        remaining--;
        if (remaining == 0) expWait = 1'b1;
      end
      @(posedge clk21m);
      #1 checkOutput({tag, " wait_n"}, 32'(bus.wait_n), 32'(expWait));
      if (!bus.wait_n) lowCount++;
      #2;
    end
    checkOutput({tag, " wait low cycles"}, lowCount, 6 * M1_WAIT);
    idleBus();
    repeat (2) @(posedge clk21m);
  endtask

  task automatic resetMidWait();
    logic [15:0] a;
    a = 16'h1234;
    alignToCe();
    expQ.push_back(predict("reset mid wait fetch", 1'b0, 1'b1, 1'b1, 1'b0, a));
    driveBus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, a, 8'h00);
    @(posedge clk21m);
    #1 checkOutput("wait_n low before reset", 32'(bus.wait_n), 32'd0);
    #2 reset = 1'b1;
    @(posedge clk21m);
    #1 checkOutput("wait_n released by reset", 32'(bus.wait_n), 32'd1);
    #2;
    idleBus();
    reset = 1'b0;
    modelReset();
    @(posedge clk21m);
  endtask

  // Monitor: every new IORQ/MREQ cycle must match the oldest prediction.
  initial begin
    exp_t e;
    bit   prev, active;
    prev = 1'b0;
    forever begin
      @(negedge clk21m);
      active = !bus.mreq_n || !bus.iorq_n;
      if (active && !prev) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected bus cycle at %0h: got cycle, expected none", bus.addr);
        end else begin
          e = expQ.pop_front();
          checkOutput({e.tag, " d_to_cpu"}, 32'(bus.d_to_cpu), 32'(e.d));
          checkOutput({e.tag, " dataBusRQ"}, 32'(bus.dataBusRQ), 32'(e.rq));
          checkOutput({e.tag, " SLTSL_n"}, 32'(bus.SLTSL_n), 32'(e.sltsl));
          checkOutput({e.tag, " slot"}, 32'(bus.slot), 32'(e.slot));
          checkOutput({e.tag, " sub_slot"}, 32'(bus.sub_slot), 32'(e.sub));
        end
      end
      prev = active;
    end
  end

  initial begin
    logic [15:0] a;
    logic [7:0]  d;
    idleBus();
    modelReset();
    reset = 1'b1;
    repeat (3) @(posedge clk21m);
    #3 reset = 1'b0;
    @(negedge clk21m);
    checkOutput("reset wait_n", 32'(bus.wait_n), 32'd1);
    checkOutput("reset d_to_cpu", 32'(bus.d_to_cpu), 32'hFF);
    checkOutput("reset dataBusRQ", 32'(bus.dataBusRQ), 32'd0);
    checkOutput("reset SLTSL_n", 32'(bus.SLTSL_n), 32'hF);

    applyStimulus("in A8 after reset", 1, 1, 0, 0, 16'h00A8, 8'h00, 2);
    applyStimulus("read 4000",         0, 1, 0, 0, 16'h4000, 8'h00, 2);
    applyStimulus("out A8 C0",         1, 0, 1, 0, 16'h00A8, 8'hC0, 3);
    applyStimulus("write FFFF 3C",     0, 0, 1, 0, 16'hFFFF, 8'h3C, 6);
    applyStimulus("read FFFF",         0, 1, 0, 0, 16'hFFFF, 8'h00, 2);
    applyStimulus("read 8000",         0, 1, 0, 0, 16'h8000, 8'h00, 2);
    applyStimulus("read C000",         0, 1, 0, 0, 16'hC000, 8'h00, 2);
    applyStimulus("out A8 FF",         1, 0, 1, 0, 16'h00A8, 8'hFF, 2);
    applyStimulus("read 4000 pslot FF",0, 1, 0, 0, 16'h4000, 8'h00, 2);
    applyStimulus("read 8000 pslot FF",0, 1, 0, 0, 16'h8000, 8'h00, 2);
    applyStimulus("out A8 00",         1, 0, 1, 0, 16'h00A8, 8'h00, 2);
    applyStimulus("write FFFF slot0",  0, 0, 1, 0, 16'hFFFF, 8'h55, 6);
    applyStimulus("read FFFF slot0",   0, 1, 0, 0, 16'hFFFF, 8'h00, 2);
    applyStimulus("out A8 C0 again",   1, 0, 1, 0, 16'h00A8, 8'hC0, 2);
    applyStimulus("read FFFF retarget",0, 1, 0, 0, 16'hFFFF, 8'h00, 2);
    applyStimulus("refresh cycle",     0, 0, 0, 1, 16'h4000, 8'h00, 2);

    m1WaitTest("m1 fetch", 1'b0);
    m1WaitTest("int ack", 1'b1);
    resetMidWait();
    applyStimulus("in A8 after reset2", 1, 1, 0, 0, 16'h00A8, 8'h00, 2);

    for (int n = 0; n < 300; n++) begin
      d = 8'($urandom);
      case ($urandom_range(0, 6))
        0: begin
          if ($urandom_range(0, 1) == 1) d[7:6] = 2'b11;
          a = {8'($urandom), ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hA8};
          applyStimulus("rnd io write", 1, 0, 1, 0, a, d, $urandom_range(1, 6));
        end
        1: applyStimulus("rnd in A8", 1, 1, 0, 0, {8'($urandom), 8'hA8}, d, $urandom_range(1, 4));
        2: applyStimulus("rnd io read", 1, 1, 0, 0, 16'($urandom), d, $urandom_range(1, 4));
        3: begin
          a = ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'($urandom);
          applyStimulus("rnd mem read", 0, 1, 0, 0, a, d, $urandom_range(1, 4));
        end
        4: applyStimulus("rnd write FFFF", 0, 0, 1, 0, 16'hFFFF, d, $urandom_range(1, 6));
        5: applyStimulus("rnd mem write", 0, 0, 1, 0, 16'($urandom), d, $urandom_range(1, 6));
        default: begin
          a = ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'($urandom);
          applyStimulus("rnd refresh", 0, 0, 0, 1, a, d, $urandom_range(1, 3));
        end
      endcase
    end

    repeat (3) @(posedge clk21m);
    checkOutput("scoreboard drained", expQ.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
